fetch_branch_ctrl: RTL and testbench

// - Sequencer driving the program counter's control inputs: start pulse, forward/backward branch strobes, relative target.
// - Decodes each instruction word read at the current PC, resolves branches against the ALU condition flag, detects HALT.
// - Counts dynamic instructions; runs a start/run/done handshake with the testbench or top level.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/branch_decode.sv | 32 +++
 rtl/fetch_branch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_branch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
//------------------------------------------------------------------------------
// Module      : proc_pkg
// Description : Shared opcodes, instruction width and sequencer state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package proc_pkg;

  localparam int IW = 9;

  localparam logic [2:0] OP_BR   = 3'b111;
  localparam logic [2:0] OP_BRC  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_decode.sv
//------------------------------------------------------------------------------
// Module      : branch_decode
// Description : Combinational decode of one instruction word into branch/halt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_decode
  import proc_pkg::*;
#(
  parameter int IW_P = proc_pkg::IW
) (
  input  logic [IW_P-1:0] instr,
  input  logic            cond,
  output logic            is_branch,
  output logic            dir,
  output logic [4:0]      off,
  output logic            is_halt
);

  logic [2:0] w_op;

  assign w_op      = instr[8:6];
  assign dir       = instr[5];
  assign off       = instr[4:0];
  assign is_branch = (w_op == OP_BR) || ((w_op == OP_BRC) && cond);
  // HALT needs the whole operand field clear; 101 with any other operand is a no-op
  assign is_halt   = (w_op == OP_HALT) && (instr[5:0] == 6'd0);

endmodule

`default_nettype wire

// File: rtl/fetch_branch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : fetch_branch_ctrl
// Description : Program-counter sequencer: start/run/done handshake, branch
//               strobes, dynamic instruction count. Optional taken-branch
//               statistics enabled by defining BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_branch_ctrl
  import proc_pkg::*;
#(
  parameter int               IW         = proc_pkg::IW,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             go_i,
  input  logic [7:0]       startadd_i,
  input  logic [7:0]       pc_i,
  input  logic [IW-1:0]    instr_i,
  input  logic             cond_i,
  output logic             start_o,
  output logic [7:0]       startadd_o,
  output logic             branchf_o,
  output logic             branchb_o,
  output logic [7:0]       target_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] dyn_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  localparam logic [CNT_W-1:0] C_LIMIT = MAX_CYCLES - CNT_W'(1);

  state_t           r_state;
  logic             r_start;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [7:0]       r_startadd;
  logic [CNT_W-1:0] r_dyn_count;

  logic       w_is_branch;
  logic       w_dir;
  logic [4:0] w_off;
  logic       w_is_halt;
  logic       w_run;
  logic       w_taken;
  logic       w_go;
  logic       w_pc_unused;

  branch_decode #(
    .IW_P (IW)
  ) u_decode (
    .instr     (instr_i),
    .cond      (cond_i),
    .is_branch (w_is_branch),
    .dir       (w_dir),
    .off       (w_off),
    .is_halt   (w_is_halt)
  );

  assign w_run       = (r_state == S_RUN);
  assign w_taken     = w_run && w_is_branch;
  assign w_go        = go_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  // The PC value is only observed through instr_i; the port exists for the PC hookup
  assign w_pc_unused = ^pc_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_startadd  <= 8'd0;
      r_dyn_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (go_i) begin
            r_state     <= S_START;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_startadd  <= startadd_i;
            r_dyn_count <= '0;
          end
        end
        S_START: begin
          r_state <= S_RUN;
          r_start <= 1'b0;
        end
        S_RUN: begin
          if (!(&r_dyn_count)) r_dyn_count <= r_dyn_count + CNT_W'(1);
          // HALT takes precedence so a program ending exactly at the limit is not a timeout
          if (w_is_halt || (r_dyn_count == C_LIMIT)) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= !w_is_halt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_count;

  always_ff @(posedge clock_i) begin
    if (reset_i || w_go) r_taken_count <= '0;
    else if (w_taken && !(&r_taken_count)) r_taken_count <= r_taken_count + CNT_W'(1);
  end

  assign taken_count_o = r_taken_count;
`else
  logic w_go_unused;
  assign w_go_unused   = w_go;
  assign taken_count_o = '0;
`endif

  assign start_o     = r_start;
  assign startadd_o  = r_startadd;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;
  assign dyn_count_o = r_dyn_count;
  assign branchf_o   = w_taken && !w_dir;
  assign branchb_o   = w_taken && w_dir;
  assign target_o    = w_taken ? {3'b000, w_off} : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_branch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_branch_ctrl
// Description : Self-checking bench for fetch_branch_ctrl with a PC and imem.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_branch_ctrl;

  localparam int CNT_W = 16;
  localparam int MAXC  = 8;
  localparam logic [8:0] HALT = 9'b101_000000;

  logic             clock_i = 1'b0;
  logic             reset_i, go_i, cond_i;
  logic [7:0]       startadd_i, pc;
  logic [8:0]       instr_i;
  logic             start_o, branchf_o, branchb_o, busy_o, done_o, timeout_o;
  logic [7:0]       startadd_o, target_o;
  logic [CNT_W-1:0] dyn_count_o, taken_count_o;

  logic [8:0] imem [256];
  logic       tbl_mode;
  logic [8:0] tbl_instr;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [8:0] instr;
    logic       cond;
    logic       bf;
    logic       bb;
    logic [7:0] tgt;
  } vec_t;
  vec_t tbl [8];

  fetch_branch_ctrl #(
    .IW(9), .CNT_W(CNT_W), .MAX_CYCLES(16'd8)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .go_i(go_i), .startadd_i(startadd_i),
    .pc_i(pc), .instr_i(instr_i), .cond_i(cond_i), .start_o(start_o),
    .startadd_o(startadd_o), .branchf_o(branchf_o), .branchb_o(branchb_o),
    .target_o(target_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .dyn_count_o(dyn_count_o), .taken_count_o(taken_count_o)
  );

  always #5 clock_i = ~clock_i;

  assign instr_i = tbl_mode ? tbl_instr : imem[pc];

  // Program counter driven by the DUT's control outputs
  always_ff @(posedge clock_i) begin
    if (reset_i)        pc <= 8'd0;
    else if (start_o)   pc <= startadd_o;
    else if (branchf_o) pc <= pc + target_o;
    else if (branchb_o) pc <= pc - target_o;
    else                pc <= pc + 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_taken(input int n);
`ifdef BRANCH_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic start_run(input logic [7:0] addr);
    go_i = 1'b1;
    startadd_i = addr;
    @(negedge clock_i);
    go_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(start_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
    chk({tag, "_startadd"}, 32'(startadd_o), 0);
    chk({tag, "_strobes"}, 32'({branchf_o, branchb_o, target_o}), 0);
    chk({tag, "_dyn"}, 32'(dyn_count_o), 0);
    chk({tag, "_taken"}, 32'(taken_count_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mpc, sa;
    logic [8:0] minstr;
    logic [31:0] rnd;
    int         mcnt, mtaken, mto;
    logic       fin, c, tk, halt;

    reset_i = 1'b1; go_i = 1'b0; cond_i = 1'b0; startadd_i = 8'd0;
    tbl_mode = 1'b0; tbl_instr = 9'd0;
    for (int i = 0; i < 256; i++) imem[i] = 9'd0;

    tbl[0] = '{9'b111_0_00101, 1'b0, 1'b1, 1'b0, 8'h05};
    tbl[1] = '{9'b110_1_00011, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{9'b110_1_00011, 1'b1, 1'b0, 1'b1, 8'h03};
    tbl[3] = '{9'b111_1_11111, 1'b0, 1'b0, 1'b1, 8'h1F};
    tbl[4] = '{9'b110_0_10000, 1'b1, 1'b1, 1'b0, 8'h10};
    tbl[5] = '{9'b000_1_11111, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{9'b101_0_00001, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{9'b100_0_00100, 1'b1, 1'b0, 1'b0, 8'h00};

    repeat (2) @(negedge clock_i);
    chk_idle_outputs("reset");
    reset_i = 1'b0;

    // Directed run at 0x10: two NOPs, forward +5, conditional back not taken, HALT
    imem[8'h12] = 9'b111_0_00101;
    imem[8'h17] = 9'b110_1_00011;
    imem[8'h18] = HALT;
    go_i = 1'b1; startadd_i = 8'h10;
    @(negedge clock_i);
    go_i = 1'b0;
    chk("start_pulse", 32'(start_o), 1);
    chk("startadd_cap", 32'(startadd_o), 32'h10);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_strobes", 32'({branchf_o, branchb_o}), 0);
    @(negedge clock_i);
    chk("run_busy", 32'(busy_o), 1);
    chk("run_start_low", 32'(start_o), 0);
    chk("run_pc_loaded", 32'(pc), 32'h10);
    chk("run_strobes0", 32'({branchf_o, branchb_o}), 0);
    repeat (2) @(negedge clock_i);
    chk("fwd_bf", 32'(branchf_o), 1);
    chk("fwd_bb", 32'(branchb_o), 0);
    chk("fwd_tgt", 32'(target_o), 5);
    @(negedge clock_i);
    chk("fwd_pc", 32'(pc), 32'h17);
    chk("brc_nt_strobes", 32'({branchf_o, branchb_o, target_o}), 0);
    @(negedge clock_i);
    chk("brc_nt_pc", 32'(pc), 32'h18);
    @(negedge clock_i);
    chk("seq1_done", 32'(done_o), 1);
    chk("seq1_busy", 32'(busy_o), 0);
    chk("seq1_dyn", 32'(dyn_count_o), 5);
    chk("seq1_to", 32'(timeout_o), 0);

    // Four-instruction program ending in HALT; go accepted from DONE
    imem[8'h43] = HALT;
    imem[8'h44] = 9'b111_0_00001;
    start_run(8'h40);
    repeat (4) @(negedge clock_i);
    chk("halt4_done", 32'(done_o), 1);
    chk("halt4_dyn", 32'(dyn_count_o), 4);
    chk("halt4_to", 32'(timeout_o), 0);
    repeat (2) @(negedge clock_i);
    chk("halt4_hold", 32'(done_o), 1);
    chk("done_strobes", 32'({branchf_o, branchb_o, target_o}), 0);

    // Self-loop: only the cycle limit ends it
    imem[8'h80] = 9'b111_0_00000;
    start_run(8'h80);
    repeat (7) @(negedge clock_i);
    chk("loop_busy7", 32'(busy_o), 1);
    chk("loop_dyn7", 32'(dyn_count_o), 7);
    @(negedge clock_i);
    chk("loop_done", 32'(done_o), 1);
    chk("loop_to", 32'(timeout_o), 1);
    chk("loop_dyn", 32'(dyn_count_o), 8);
    chk("loop_taken", 32'(taken_count_o), exp_taken(8));

    // HALT on the limit cycle: not a timeout
    imem[8'h97] = HALT;
    start_run(8'h90);
    chk("go_clears_to", 32'(timeout_o), 0);
    repeat (8) @(negedge clock_i);
    chk("hl_done", 32'(done_o), 1);
    chk("hl_to", 32'(timeout_o), 0);
    chk("hl_dyn", 32'(dyn_count_o), 8);

    // Three taken branches then HALT
    imem[8'hA0] = 9'b111_0_00010;
    imem[8'hA2] = 9'b111_1_00001;
    imem[8'hA1] = 9'b111_0_00011;
    imem[8'hA4] = HALT;
    start_run(8'hA0);
    repeat (4) @(negedge clock_i);
    chk("tk3_done", 32'(done_o), 1);
    chk("tk3_dyn", 32'(dyn_count_o), 4);
    chk("tk3_taken", 32'(taken_count_o), exp_taken(3));

    // Table vectors applied one per RUN cycle
    tbl_mode = 1'b1;
    start_run(8'h00);
    for (int i = 0; i < 8; i++) begin
      tbl_instr = tbl[i].instr;
      cond_i = tbl[i].cond;
      #1;
      chk($sformatf("tbl%0d_bf", i), 32'(branchf_o), 32'(tbl[i].bf));
      chk($sformatf("tbl%0d_bb", i), 32'(branchb_o), 32'(tbl[i].bb));
      chk($sformatf("tbl%0d_tgt", i), 32'(target_o), 32'(tbl[i].tgt));
      @(negedge clock_i);
    end
    chk("tbl_done", 32'(done_o), 1);
    chk("tbl_to", 32'(timeout_o), 1);
    chk("tbl_taken", 32'(taken_count_o), exp_taken(4));
    tbl_mode = 1'b0;
    cond_i = 1'b0;

    // Reset in the middle of a run
    start_run(8'h80);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    chk_idle_outputs("midreset");
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("after_reset_idle", 32'({busy_o, done_o, start_o}), 0);

    // Random programs against a program-execution reference
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 256; a++) begin
        rnd = $urandom();
        imem[a] = ($urandom_range(0, 5) == 0) ? HALT : rnd[8:0];
      end
      rnd = $urandom();
      sa = rnd[7:0];
      start_run(sa);
      mpc = sa; mcnt = 0; mtaken = 0; mto = 0; fin = 1'b0;
      for (int k = 0; k < MAXC && !fin; k++) begin
        c = 1'($urandom_range(0, 1));
        cond_i = c;
        #1;
        minstr = imem[mpc];
        halt = (minstr[8:6] == 3'b101) && (minstr[5:0] == 6'd0);
        tk = (minstr[8:6] == 3'b111) || ((minstr[8:6] == 3'b110) && c);
        chk($sformatf("rnd%0d_pc%0d", r, k), 32'(pc), 32'(mpc));
        chk($sformatf("rnd%0d_br%0d", r, k), 32'({branchf_o, branchb_o, target_o}),
            tk ? 32'({~minstr[5], minstr[5], 3'b000, minstr[4:0]}) : 0);
        if (tk) begin
          mpc = minstr[5] ? mpc - {3'b000, minstr[4:0]} : mpc + {3'b000, minstr[4:0]};
          mtaken++;
        end else begin
          mpc = mpc + 8'd1;
        end
        mcnt++;
        if (halt) fin = 1'b1;
        else if (mcnt == MAXC) begin fin = 1'b1; mto = 1; end
        @(negedge clock_i);
      end
      chk($sformatf("rnd%0d_done", r), 32'({done_o, busy_o}), 32'h2);
      chk($sformatf("rnd%0d_dyn", r), 32'(dyn_count_o), mcnt);
      chk($sformatf("rnd%0d_to", r), 32'(timeout_o), mto);
      chk($sformatf("rnd%0d_taken", r), 32'(taken_count_o), exp_taken(mtaken));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
